// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller for SHA3-256/512 and SHAKE128/256: owns the 1600-bit state, pads and absorbs
// message lanes, and squeezes output lanes. Keccak-f[1600] lives outside, behind start/done.
module keccak_sponge_ctrl #(
    parameter int LANE_W    = 64,
    parameter int OUT_LEN_W = 16,
    parameter int PERM_W    = 1600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [OUT_LEN_W-1:0] out_lanes,
    input  logic [LANE_W-1:0]    in_data,
    input  logic [3:0]           in_bytes,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [LANE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 perm_start,
    output logic [PERM_W-1:0]    perm_din,
    input  logic                 perm_done,
    input  logic [PERM_W-1:0]    perm_dout,
    output logic                 busy
);
    localparam int LB = LANE_W / 8;

    typedef enum logic [2:0] {IDLE, ABSORB, PERM_A, PAD_BLK, PERM_S, SQUEEZE} fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [PERM_W-1:0]    state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [OUT_LEN_W-1:0] len_q, len_d;
    logic [OUT_LEN_W-1:0] remaining_q, remaining_d;
    logic [4:0]           lane_idx_q, lane_idx_d;
    logic [4:0]           sq_idx_q, sq_idx_d;
    logic                 final_q, final_d;
    logic                 pad_pending_q, pad_pending_d;
    logic                 perm_start_q, perm_start_d;

    logic [4:0]           rate_m1;
    logic [7:0]           dom;
    logic                 short_last;
    logic [LANE_W-1:0]    word;
    int                   abs_base, nxt_base, pad_base, sq_base;

    always_comb begin
        rate_m1 = 5'd16;
        dom     = 8'h06;
        case (mode_q)
            2'd0: begin rate_m1 = 5'd16; dom = 8'h06; end
            2'd1: begin rate_m1 = 5'd8;  dom = 8'h06; end
            2'd2: begin rate_m1 = 5'd20; dom = 8'h1F; end
            default: begin rate_m1 = 5'd16; dom = 8'h1F; end
        endcase
    end

    always_comb begin
        abs_base = int'(lane_idx_q) * LANE_W;
        nxt_base = abs_base + LANE_W;
        pad_base = int'(rate_m1) * LANE_W + LANE_W - 8;
        sq_base  = int'(sq_idx_q) * LANE_W;
    end

    // Final word: bytes past in_bytes are dropped and the domain byte lands right after the data.
    always_comb begin
        short_last = in_last && (in_bytes < 4'd8);
        word       = in_data;
        for (int b = 0; b < LB; b++) begin
            if (in_last && (4'(b) >= in_bytes)) word[8*b +: 8] = 8'h00;
        end
        if (short_last) word[int'(in_bytes[2:0])*8 +: 8] = word[int'(in_bytes[2:0])*8 +: 8] ^ dom;
    end

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        mode_d        = mode_q;
        len_d         = len_q;
        remaining_d   = remaining_q;
        lane_idx_d    = lane_idx_q;
        sq_idx_d      = sq_idx_q;
        final_d       = final_q;
        pad_pending_d = pad_pending_q;
        perm_start_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d       = '0;
                    mode_d        = mode;
                    lane_idx_d    = '0;
                    final_d       = 1'b0;
                    pad_pending_d = 1'b0;
                    if (mode == 2'd0)           len_d = OUT_LEN_W'(4);
                    else if (mode == 2'd1)      len_d = OUT_LEN_W'(8);
                    else if (out_lanes == '0)   len_d = OUT_LEN_W'(1);
                    else                        len_d = out_lanes;
                    fsm_d = ABSORB;
                end
            end
            ABSORB: begin
                if (in_valid) begin
                    state_d[abs_base +: LANE_W] = state_q[abs_base +: LANE_W] ^ word;
                    if (!in_last) begin
                        if (lane_idx_q == rate_m1) begin
                            lane_idx_d   = '0;
                            perm_start_d = 1'b1;
                            fsm_d        = PERM_A;
                        end else begin
                            lane_idx_d = lane_idx_q + 5'd1;
                        end
                    end else begin
                        lane_idx_d   = '0;
                        perm_start_d = 1'b1;
                        fsm_d        = PERM_A;
                        if (short_last) begin
                            final_d = 1'b1;
                            state_d[pad_base +: 8] = state_d[pad_base +: 8] ^ 8'h80;
                        end else if (lane_idx_q != rate_m1) begin
                            final_d = 1'b1;
                            state_d[nxt_base +: 8] = state_d[nxt_base +: 8] ^ dom;
                            state_d[pad_base +: 8] = state_d[pad_base +: 8] ^ 8'h80;
                        end else begin
                            pad_pending_d = 1'b1;
                        end
                    end
                end
            end
            PERM_A: begin
                if (perm_done) begin
                    state_d = perm_dout;
                    if (pad_pending_q) begin
                        fsm_d = PAD_BLK;
                    end else if (final_q) begin
                        sq_idx_d    = '0;
                        remaining_d = len_q;
                        fsm_d       = SQUEEZE;
                    end else begin
                        fsm_d = ABSORB;
                    end
                end
            end
            // Message filled the block exactly, so the padding occupies a block of its own.
            PAD_BLK: begin
                state_d[7:0]           = state_q[7:0] ^ dom;
                state_d[pad_base +: 8] = state_d[pad_base +: 8] ^ 8'h80;
                perm_start_d           = 1'b1;
                final_d                = 1'b1;
                pad_pending_d          = 1'b0;
                fsm_d                  = PERM_A;
            end
            SQUEEZE: begin
                if (out_ready) begin
                    if (remaining_q != '0) remaining_d = remaining_q - OUT_LEN_W'(1);
                    sq_idx_d = sq_idx_q + 5'd1;
                    if (remaining_q <= OUT_LEN_W'(1)) begin
                        fsm_d = IDLE;
                    end else if (sq_idx_q == rate_m1) begin
                        perm_start_d = 1'b1;
                        fsm_d        = PERM_S;
                    end
                end
            end
            PERM_S: begin
                if (perm_done) begin
                    state_d  = perm_dout;
                    sq_idx_d = '0;
                    fsm_d    = SQUEEZE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            mode_q        <= '0;
            len_q         <= '0;
            remaining_q   <= '0;
            lane_idx_q    <= '0;
            sq_idx_q      <= '0;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            perm_start_q  <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
            remaining_q   <= remaining_d;
            lane_idx_q    <= lane_idx_d;
            sq_idx_q      <= sq_idx_d;
            final_q       <= final_d;
            pad_pending_q <= pad_pending_d;
            perm_start_q  <= perm_start_d;
        end
    end

    // perm_start is registered so that perm_din already holds the freshly absorbed state.
    assign perm_start = perm_start_q;
    assign perm_din   = state_q;
    assign busy       = (fsm_q != IDLE);
    assign in_ready   = (fsm_q == ABSORB);
    assign out_valid  = (fsm_q == SQUEEZE);
    assign out_last   = out_valid && (remaining_q == OUT_LEN_W'(1));
    assign out_data   = out_valid ? state_q[sq_base +: LANE_W] : '0;

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Parametrised sponge controller for SHA3-256/512 and SHAKE128/256. It owns the 1600-bit state and performs byte-accurate padding and lane-wise XOR absorb. Squeeze length is runtime-programmable; multi-block squeeze re-permutes automatically. Keccak-f[1600] is external, behind a start/done handshake; the block sits between the seed source and the parse/CBD consumers, with valid/ready on both streams.

Parameters:
LANE_W, 64, lane/stream width in bits; fixed at 64 for Keccak-f[1600], bytes per lane = LANE_W/8.
OUT_LEN_W, 16, width of out_lanes request.
PERM_W, 1600, state width on permutation interface.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin new hash; sampled only in IDLE
mode  in  2  0 SHA3-256, 1 SHA3-512, 2 SHAKE128, 3 SHAKE256; latched at start
out_lanes  in  OUT_LEN_W  SHAKE output length in lanes; latched at start
in_data  in  LANE_W  message lane, little-endian bytes (byte k = bits 8k+7:8k)
in_bytes  in  4  valid bytes in in_data when in_last (0..8)
in_last  in  1  final message word
in_valid  in  1  input handshake
in_ready  out  1  input handshake
out_data  out  LANE_W  squeezed lane
out_valid  out  1  output handshake
out_ready  in  1  output handshake
out_last  out  1  marks final output lane
perm_start  out  1  one-cycle pulse: permute perm_din
perm_din  out  PERM_W  current state (lane i = bits 64i+63:64i)
perm_done  in  1  one-cycle pulse: perm_dout valid, latency arbitrary
perm_dout  in  PERM_W  permuted state
busy  out  1  high outside IDLE

Behaviour:
- Reset: FSM=IDLE, state=0, all counters 0; in_ready, out_valid, out_last, perm_start, busy = 0; out_data = 0.
- Rate R (lanes) / domain byte D: mode0 17/0x06, mode1 9/0x06, mode2 21/0x1F, mode3 17/0x1F.
- Output length L: mode0 4, mode1 8, modes2/3 out_lanes (0 treated as 1).
- States: IDLE, ABSORB, PERM_A, PAD_BLK, PERM_S, SQUEEZE.
- IDLE: start -> clear state, latch mode/L, lane_idx=0, go ABSORB next cycle. Start is ignored when not in IDLE.
- ABSORB: in_ready=1.
  - On each handshake: state lane[lane_idx] ^= in_data. If in_last, bytes >= in_bytes are masked to 0.
  - Non-last word with lane_idx=R-1: perm_start, go PERM_A; lane_idx resets to 0.
  - Last word, in_bytes<8: XOR D into byte in_bytes of the same lane and 0x80 into byte 7 of lane R-1, same cycle. If both land on the same byte, the XOR yields 0x86/0x9F. Then perm_start, final=1, go PERM_A.
  - Last word, in_bytes=8, lane_idx<R-1: D goes into byte 0 of lane lane_idx+1, 0x80 into lane R-1; final=1, go PERM_A.
  - Last word, in_bytes=8, lane_idx=R-1: pad_pending=1, go PERM_A with final=0.
- PERM_A: in_ready=0; wait perm_done, state<=perm_dout.
  - pad_pending -> PAD_BLK.
  - final -> SQUEEZE (sq_idx=0, remaining=L).
  - else -> ABSORB.
- PAD_BLK: one cycle; lane0 ^= D, lane R-1 ^= 0x80<<56, perm_start, final=1, pad_pending=0, go PERM_A.
- SQUEEZE: out_valid=1, out_data=lane[sq_idx], out_last=(remaining==1).
  - out_data/out_last hold stable while out_ready=0.
  - On handshake: remaining--, sq_idx++.
  - remaining hits 0 -> IDLE next cycle, out_valid drops.
  - sq_idx hits R with remaining>0 -> perm_start, go PERM_S, out_valid=0.
- PERM_S: wait perm_done, state<=perm_dout, sq_idx=0, go SQUEEZE.
- perm_start asserts exactly one cycle per permutation; perm_din is stable from perm_start until perm_done.
- perm_done outside PERM_A/PERM_S is ignored.
- Reset at any time aborts immediately; no output is produced for the aborted hash.
- Counters: lane_idx/sq_idx are 5 bits (max 20); remaining is OUT_LEN_W bits and never wraps.

Test Plan:
- SHA3-256 empty message with real Keccak-f model: start mode0; one word in_last in_bytes=0 -> 4 lanes, lane0=0x66D71EBFF8C6FFA7, out_last on lane 3, one perm_start.
- Identity-stub padding check (perm_dout=perm_din, latency 3): mode0, in_data=0x1122334455667788, in_bytes=3 -> lane0=0x0000000006667788, lanes1-3=0, single perm_start.
- Rate boundary: mode3, 17 words w0..w16, last with in_bytes=8, identity stub -> two absorb perm_starts; lane0 out = w0^0x1F; state lane16 = w16^0x8000000000000000 (check via perm_din).
- Multi-block squeeze: mode2, out_lanes=25, one short word -> 21 lanes, then perm_start (total 2), then 4 lanes; out_last only on lane 25; busy falls next cycle.
- Backpressure/ignore: out_ready low 5 cycles mid-squeeze -> out_data/out_valid stable; start pulsed while busy -> no effect; extra perm_done in SQUEEZE ignored.
- Reset mid-ABSORB after 5 words -> all outputs 0 next cycle; new start mode1 hashes correctly (9-lane rate, 8 output lanes).
